// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding word-bus access per request, with byte-lane steering,
// load sign/zero extension, misalignment/illegal-op faults and a mem_ready timeout.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          bus_err_q, bus_err_d;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   addr_q, wdata_q;
    logic          legal, accept;
    logic [3:0]    be;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~req_addr[0];
            3'b010:  legal = (req_addr[1:0] == 2'b00);
            3'b100:  legal = ~req_we;
            3'b101:  legal = ~req_we & ~req_addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        be = 4'b1111;
        if (we_q) begin
            case (f3_q[1:0])
                2'b00:   be = 4'b0001 << addr_q[1:0];
                2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        case (f3_q[1:0])
            2'b00:   mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   mem_wdata = {2{wdata_q[15:0]}};
            default: mem_wdata = wdata_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        bus_err_d = 1'b0;
        stall     = 1'b0;
        fault     = 1'b0;
        mem_req   = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (legal) begin
                        stall   = 1'b1;
                        accept  = 1'b1;
                        state_d = BUSY;
                    end else begin
                        // gated so a held request cannot pulse fault while in reset
                        fault = reset;
                    end
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ready) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!we_q) rdata_d = ld_ext;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d     = '0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    assign rdata    = rdata_q;
    assign bus_err  = bus_err_q;
    assign mem_we   = mem_req & we_q;
    assign mem_be   = mem_req ? be : 4'b0000;
    assign mem_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random accesses against a byte-level model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, fault, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_rdata = 32'd0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .fault(fault), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return (int'(a[1:0]) % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int sz = m_size(f3);
        if (!we) return 4'hF;
        return 4'(((1 << sz) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v = longint'(rd >> (8 * a[1:0]));
        int n = 8 * m_size(f3);
        if (n < 32) begin
            v = v & ((longint'(1) << n) - 1);
            if (!f3[2] && v[n-1]) v = v - (longint'(1) << n);
        end
        return v[31:0];
    endfunction

    // Drives one request starting #1 after a posedge in IDLE; d = BUSY cycle index at which mem_ready rises.
    task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int d, input bit hold);
        int nb;
        bit to;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        mem_ready = 1'b0; mem_rdata = rd;
        #1;
        if (!m_legal(we, f3, a)) begin
            chk("fault_pulse", fault, 1'b1);
            chk("fault_stall", stall, 1'b0);
            chk("fault_memreq", mem_req, 1'b0);
            chk("fault_buserr", bus_err, 1'b0);
            @(posedge clk); #1;
            chk("fault_stay_idle", mem_req, 1'b0);
            req_valid = 1'b0;
            #1;
            chk("fault_rdata", rdata, exp_rdata);
            chk("fault_clear", fault, 1'b0);
        end else begin
            chk("idle_stall", stall, 1'b1);
            chk("idle_memreq", mem_req, 1'b0);
            chk("idle_fault", fault, 1'b0);
            to = (d >= TO);
            nb = to ? TO : d + 1;
            for (int i = 0; i < nb; i++) begin
                @(posedge clk); #1;
                chk("busy_memreq", mem_req, 1'b1);
                chk("busy_stall", stall, 1'b1);
                chk("busy_we", mem_we, we);
                chk("busy_addr", mem_addr, {a[31:2], 2'b00});
                chk("busy_be", mem_be, m_be(we, f3, a));
                if (we) chk("busy_wdata", mem_wdata, m_wdata(f3, wd));
                chk("busy_buserr", bus_err, 1'b0);
                mem_ready = (i == d);
            end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (!hold) req_valid = 1'b0;
            if (!we) exp_rdata = to ? 32'd0 : m_load(f3, a, rd);
            chk("done_stall", stall, 1'b0);
            chk("done_memreq", mem_req, 1'b0);
            chk("done_be", mem_be, 4'h0);
            chk("done_buserr", bus_err, to);
            chk("done_fault", fault, 1'b0);
            chk("done_rdata", rdata, exp_rdata);
            @(posedge clk); #1;
            chk("next_buserr", bus_err, 1'b0);
            if (!hold) begin
                chk("idle_after_memreq", mem_req, 1'b0);
                chk("idle_after_stall", stall, 1'b0);
            end
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        #3;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_memreq", mem_req, 1'b0);
        chk("rst_memwe", mem_we, 1'b0);
        chk("rst_membe", mem_be, 4'h0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_buserr", bus_err, 1'b0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // directed scenarios
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0);
        access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 1'b0);
        access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1, 1'b0);
        access(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b0);
        access(1'b1, 3'b100, 32'h200, 32'h55, 32'h0, 0, 1'b0);
        access(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 1'b0);
        access(1'b0, 3'b010, 32'h300, 32'h0, 32'h12345678, 100, 1'b0);
        access(1'b0, 3'b101, 32'h302, 32'h0, 32'hF00DBEEF, 3, 1'b0);

        // reset while BUSY abandons the access
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_memreq", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        exp_rdata = 32'd0;
        chk("midrst_memreq", mem_req, 1'b0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_be", mem_be, 4'h0);
        req_valid = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("postrst_memreq", mem_req, 1'b0);
        access(1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFEF00D, 0, 1'b0);

        // back-to-back with req_valid held across DONE
        access(1'b0, 3'b010, 32'h500, 32'h0, 32'h01020304, 0, 1'b1);
        access(1'b1, 3'b010, 32'h504, 32'hA5A5A5A5, 32'h0, 0, 1'b0);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 5)), 1'($urandom));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("final_memreq", mem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // fault and bus_err must never coincide
    always @(negedge clk) begin
        if (fault && bus_err) begin
            fails++;
            $display("FAIL fault_buserr_overlap: observed 1 expected 0");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waiting for mem_ready before a bus error.
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  core requests a load/store this cycle.
REQ-005 req_we  in  1  1=store, 0=load.
REQ-006 req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
REQ-007 req_addr  in  32  byte address (ALU result).
REQ-008 req_wdata  in  32  store data (rs2).
REQ-009 stall  out  1  core must hold PC and request inputs.
REQ-010 rdata  out  32  extended load result, registered.
REQ-011 fault  out  1  one-cycle pulse: misaligned or illegal request.
REQ-012 bus_err  out  1  one-cycle pulse: memory timeout.
REQ-013 mem_req, mem_we  out  1 each  memory request / write strobe.
REQ-014 mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00}).
REQ-015 mem_wdata  out  32  lane-replicated store data; mem_be  out  4  byte enables.
REQ-016 mem_ready  in  1; mem_rdata  in  32  memory completion and read word.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-018 IDLE, req_valid=1, legal and aligned: stall=1 combinationally; latch request; next state BUSY.
REQ-019 IDLE, req_valid=1, illegal funct3 or misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0): fault=1 for that cycle, stall=0, no memory access, rdata unchanged, remain IDLE.
REQ-020 Store funct3 100/101 SHALL be illegal.
REQ-021 BUSY: mem_req=1, stall=1; mem_addr/mem_we/mem_be/mem_wdata driven from the latched request and stable until mem_ready.
REQ-022 BUSY, mem_ready=1: load captures extended data into rdata; next state DONE; wait counter clears.
REQ-023 BUSY, mem_ready=0: wait counter increments; if it reaches TIMEOUT, bus_err pulses 1 cycle, rdata=0 for loads, next state DONE.
REQ-024 DONE: stall=0, mem_req=0, req_valid ignored; next state IDLE unconditionally, so the retiring instruction's request is not re-issued.
REQ-025 Zero-wait memory: stall high 2 cycles (IDLE, BUSY); rdata valid in DONE; 3 cycles per access.
REQ-026 mem_be: SB 4'b0001<<addr[1:0]; SH addr[1]?4'b1100:4'b0011; SW 4'b1111; loads 4'b1111.
REQ-027 mem_wdata: SB byte replicated x4; SH halfword replicated x2; SW unchanged.
REQ-028 Load extraction: byte lane addr[1:0]; half lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
REQ-029 mem_req, mem_we, mem_be SHALL be 0 whenever the state is not BUSY.
REQ-030 fault and bus_err SHALL never be asserted in the same cycle.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for clk, force state IDLE, rdata=0, wait counter=0, fault=0, bus_err=0, mem_req=0, mem_we=0, mem_be=0.
REQ-032 Reset asserted in BUSY SHALL abandon the access; after release, the first req_valid starts a fresh access.
REQ-033 The first rising clk edge after reset deassertion SHALL be a normal IDLE cycle.

Verification
REQ-034 SW addr 0x100, wdata 0xDEADBEEF, mem_ready tied 1 -> stall 1 for 2 cycles, mem_be=1111, mem_addr=0x100, one mem_we cycle.
REQ-035 LB addr 0x103, mem_rdata 0x80FF1234 -> rdata=0xFFFFFF80 in DONE; LBU same -> 0x00000080.
REQ-036 SH addr 0x102, wdata 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD; LH addr 0x101 -> fault pulse, no mem_req, stall=0.
REQ-037 LW, mem_ready held 0, TIMEOUT=4 -> bus_err pulse after 4 BUSY cycles, rdata=0, then IDLE.
REQ-038 LW with mem_ready delayed 3 cycles, then reset=0 asserted mid-BUSY -> mem_req drops immediately, rdata=0; next LW completes normally.
REQ-039 Back-to-back LW then SW with req_valid held high -> each access issued exactly once, DONE separating them.
